dsm_modulator: RTL and testbench

- First-order error-feedback delta-sigma modulator: accepts unsigned PCM samples over a valid/ready handshake and emits one OUT_W-bit DSM code per output tick.
- Sits directly upstream of the DSM buffer; dsm_out/dsm_strobe feed the buffer's external-side sample input and write clock.
- Each PCM sample is held for OSR output ticks, with a one-entry look-ahead register and underrun/saturation flags.

---
 rtl/dsm_modulator.sv | 173 +++++++++++++++++
 tb/tb_dsm_modulator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_modulator.sv
// First-order error-feedback delta-sigma modulator: unsigned PCM samples in over
// valid/ready, one OUT_W-bit code per output tick, each sample held for OSR ticks.
module dsm_modulator #(
    parameter int DATA_W  = 16,
    parameter int OUT_W   = 4,
    parameter int CLK_DIV = 4,
    parameter int OSR     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] pcm_in,
    input  logic              pcm_valid,
    output logic              pcm_ready,
    output logic [OUT_W-1:0]  dsm_out,
    output logic              dsm_strobe,
    output logic              underrun,
    output logic              saturated
);

    localparam int LSB_W = DATA_W - OUT_W;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int OSR_W = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [DATA_W-1:0] XMAX     = {{OUT_W{1'b1}}, {LSB_W{1'b0}}};
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [OSR_W-1:0]  OSR_LAST = OSR_W'(OSR - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Largest sample the quantiser can represent without overflowing the code.
    function automatic logic [DATA_W-1:0] clamp_sample(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        if (x > XMAX) begin
            r = XMAX;
        end else begin
            r = x;
        end
        return r;
    endfunction

    function automatic logic is_clamped(input logic [DATA_W-1:0] x);
        return (x > XMAX);
    endfunction

    state_t            state_r, state_s;
    logic [DATA_W-1:0] next_r, next_s;
    logic              next_full_r, next_full_s;
    logic [DATA_W-1:0] cur_r, cur_s;
    logic [DATA_W-1:0] acc_r, acc_s;
    logic [DIV_W-1:0]  div_r, div_s;
    logic [OSR_W-1:0]  osr_r, osr_s;
    logic [OUT_W-1:0]  dout_s;
    logic              strobe_s;
    logic              underrun_s;
    logic              sat_s;
    logic              xfer_s;
    logic              load_s;
    logic [DATA_W-1:0] sum_s;
    logic [OUT_W-1:0]  q_s;

    assign pcm_ready = !next_full_r && !reset;
    assign xfer_s    = pcm_valid && pcm_ready;
    assign sum_s     = acc_r + cur_r;
    assign q_s       = sum_s[DATA_W-1:LSB_W];

    // Next-state logic: tick divider, quantiser, sample sequencing and look-ahead slot.
    always_comb begin
        state_s    = state_r;
        next_s     = next_r;
        next_full_s = next_full_r;
        cur_s      = cur_r;
        acc_s      = acc_r;
        div_s      = div_r;
        osr_s      = osr_r;
        dout_s     = dsm_out;
        strobe_s   = 1'b0;
        underrun_s = 1'b0;
        sat_s      = saturated;
        load_s     = 1'b0;

        case (state_r)
            IDLE: begin
                if (next_full_r) begin
                    load_s  = 1'b1;
                    acc_s   = {DATA_W{1'b0}};
                    div_s   = {DIV_W{1'b0}};
                    osr_s   = {OSR_W{1'b0}};
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (enable) begin
                    if (div_r == DIV_LAST) begin
                        div_s    = {DIV_W{1'b0}};
                        // Residual below one code step is fed back into the next tick.
                        acc_s    = sum_s - {q_s, {LSB_W{1'b0}}};
                        dout_s   = q_s;
                        strobe_s = 1'b1;
                        if (osr_r == OSR_LAST) begin
                            osr_s = {OSR_W{1'b0}};
                            if (next_full_r) begin
                                load_s = 1'b1;
                            end else begin
                                underrun_s = 1'b1;
                            end
                        end else begin
                            osr_s = osr_r + OSR_W'(1);
                        end
                    end else begin
                        div_s = div_r + DIV_W'(1);
                    end
                end else begin
                    div_s = div_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (load_s) begin
            cur_s = clamp_sample(next_r);
            sat_s = is_clamped(next_r);
        end else begin
            cur_s = cur_s;
        end

        // A handshake in the load cycle refills the slot, so no sample is dropped.
        if (xfer_s) begin
            next_s      = pcm_in;
            next_full_s = 1'b1;
        end else if (load_s) begin
            next_full_s = 1'b0;
        end else begin
            next_full_s = next_full_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            next_r      <= {DATA_W{1'b0}};
            next_full_r <= 1'b0;
            cur_r       <= {DATA_W{1'b0}};
            acc_r       <= {DATA_W{1'b0}};
            div_r       <= {DIV_W{1'b0}};
            osr_r       <= {OSR_W{1'b0}};
            dsm_out     <= {OUT_W{1'b0}};
            dsm_strobe  <= 1'b0;
            underrun    <= 1'b0;
            saturated   <= 1'b0;
        end else begin
            state_r     <= state_s;
            next_r      <= next_s;
            next_full_r <= next_full_s;
            cur_r       <= cur_s;
            acc_r       <= acc_s;
            div_r       <= div_s;
            osr_r       <= osr_s;
            dsm_out     <= dout_s;
            dsm_strobe  <= strobe_s;
            underrun    <= underrun_s;
            saturated   <= sat_s;
        end
    end

endmodule

// File: tb/tb_dsm_modulator.sv
// Directed bench for dsm_modulator: a sample-level arithmetic model checked every
// cycle, plus hand-computed code sequences for each scenario.
module tb_dsm_modulator;

    localparam int DATA_W  = 16;
    localparam int OUT_W   = 4;
    localparam int CLK_DIV = 4;
    localparam int OSR     = 8;
    localparam int STEP    = 4096;
    localparam int XMAX    = 61440;

    logic              clk;
    logic              reset;
    logic              enable;
    logic [DATA_W-1:0] pcm_in;
    logic              pcm_valid;
    logic              pcm_ready;
    logic [OUT_W-1:0]  dsm_out;
    logic              dsm_strobe;
    logic              underrun;
    logic              saturated;

    dsm_modulator #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .CLK_DIV(CLK_DIV), .OSR(OSR)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .pcm_in(pcm_in), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
        .dsm_out(dsm_out), .dsm_strobe(dsm_strobe),
        .underrun(underrun), .saturated(saturated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc_no = 0;

    // model state: running flag, look-ahead slot, current sample, error, tick bookkeeping
    int m_run, m_nf, m_next, m_cur, m_acc, m_en_cycles, m_ticks;
    int e_out, e_strobe, e_under, e_sat;

    // per-scenario capture of strobed codes
    int codes[0:63];
    int sats[0:63];
    int unders[0:63];
    int scyc[0:63];
    int n_codes;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_no, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_nf = 0; m_next = 0; m_cur = 0; m_acc = 0;
        m_en_cycles = 0; m_ticks = 0;
        e_out = 0; e_strobe = 0; e_under = 0; e_sat = 0;
    endtask

    task automatic model_step();
        int xfer, load, s;
        if (reset) begin
            model_reset();
        end else begin
            xfer = (pcm_valid && !m_nf) ? 1 : 0;
            load = 0;
            e_strobe = 0;
            e_under = 0;
            if (!m_run) begin
                if (m_nf) begin
                    load = 1;
                    m_acc = 0;
                    m_en_cycles = 0;
                    m_ticks = 0;
                    m_run = 1;
                end
            end else if (enable) begin
                m_en_cycles++;
                if (m_en_cycles % CLK_DIV == 0) begin
                    s = m_acc + m_cur;
                    e_out = s / STEP;
                    m_acc = s % STEP;
                    e_strobe = 1;
                    m_ticks++;
                    if (m_ticks % OSR == 0) begin
                        if (m_nf) load = 1;
                        else e_under = 1;
                    end
                end
            end
            if (load) begin
                m_cur = (m_next > XMAX) ? XMAX : m_next;
                e_sat = (m_next > XMAX) ? 1 : 0;
                m_nf = 0;
            end
            if (xfer) begin
                m_next = int'(pcm_in);
                m_nf = 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        cyc_no++;
        chk("dsm_out", 32'(dsm_out), 32'(e_out));
        chk("dsm_strobe", 32'(dsm_strobe), 32'(e_strobe));
        chk("underrun", 32'(underrun), 32'(e_under));
        chk("saturated", 32'(saturated), 32'(e_sat));
        chk("pcm_ready", 32'(pcm_ready), 32'((!m_nf && !reset) ? 1 : 0));
    endtask

    task automatic run_strobes(input int n, input int budget);
        int got = 0;
        int used = 0;
        while (got < n && used < budget) begin
            cyc();
            used++;
            if (dsm_strobe === 1'b1 && n_codes < 64) begin
                codes[n_codes] = int'(dsm_out);
                sats[n_codes] = int'(saturated);
                unders[n_codes] = int'(underrun);
                scyc[n_codes] = cyc_no;
                n_codes++;
                got++;
            end
        end
        chk("strobe_budget", 32'(got), 32'(n));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pcm_valid = 1'b0;
        enable = 1'b1;
        cyc();
        cyc();
        chk("ready_in_reset", 32'(pcm_ready), 32'd0);
        chk("reset_out", 32'(dsm_out), 32'd0);
        reset = 1'b0;
        n_codes = 0;
    endtask

    initial begin
        int hold, cnt, ucnt;
        int alt[0:7];
        alt = '{1, 2, 1, 2, 1, 2, 1, 2};
        reset = 1'b1; enable = 1'b1; pcm_valid = 1'b0; pcm_in = 16'h0000;
        model_reset();

        // mid-scale sample: ready drops one cycle, every code 8, strobes 4 clks apart
        do_reset();
        pcm_in = 16'h8000; pcm_valid = 1'b1;
        cyc();
        chk("ready_after_xfer", 32'(pcm_ready), 32'd0);
        cyc();
        chk("ready_after_load", 32'(pcm_ready), 32'd1);
        run_strobes(16, 200);
        for (int i = 0; i < 16; i++) begin
            chk("mid_code", 32'(codes[i]), 32'd8);
            chk("mid_sat", 32'(sats[i]), 32'd0);
        end
        chk("strobe_spacing", 32'(scyc[1] - scyc[0]), 32'd4);

        // 1.5 code steps: alternating 1,2 with sum 12 over one period
        do_reset();
        pcm_in = 16'h1800; pcm_valid = 1'b1;
        run_strobes(8, 200);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            chk("alt_code", 32'(codes[i]), 32'(alt[i]));
            cnt += codes[i];
        end
        chk("alt_sum", 32'(cnt), 32'd12);

        // saturation then zero
        do_reset();
        pcm_in = 16'hFFFF; pcm_valid = 1'b1;
        run_strobes(8, 200);
        pcm_in = 16'h0000;
        run_strobes(16, 300);
        for (int i = 0; i < 16; i++) begin
            chk("sat_code", 32'(codes[i]), 32'hF);
        end
        for (int i = 0; i < 7; i++) chk("sat_flag", 32'(sats[i]), 32'd1);
        for (int i = 16; i < 24; i++) begin
            chk("zero_code", 32'(codes[i]), 32'd0);
            chk("zero_sat", 32'(sats[i]), 32'd0);
        end

        // single sample then starvation: underrun once per period
        do_reset();
        pcm_in = 16'h4000; pcm_valid = 1'b1;
        cyc();
        pcm_valid = 1'b0;
        run_strobes(24, 400);
        ucnt = 0;
        for (int i = 0; i < 24; i++) begin
            chk("under_code", 32'(codes[i]), 32'd4);
            ucnt += unders[i];
        end
        chk("under_count", 32'(ucnt), 32'd3);
        chk("under_pos0", 32'(unders[7]), 32'd1);
        chk("under_pos1", 32'(unders[15]), 32'd1);

        // enable low mid-period freezes everything; sequence resumes unchanged
        do_reset();
        pcm_in = 16'h1800; pcm_valid = 1'b1;
        run_strobes(3, 200);
        hold = int'(dsm_out);
        enable = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (dsm_strobe === 1'b1) cnt++;
        end
        chk("disabled_strobes", 32'(cnt), 32'd0);
        chk("disabled_hold", 32'(dsm_out), 32'(hold));
        enable = 1'b1;
        run_strobes(5, 200);
        for (int i = 0; i < 8; i++) chk("resume_code", 32'(codes[i]), 32'(alt[i]));

        // reset mid-run with a pending sample: everything cleared, no strobes until new data
        pcm_valid = 1'b0;
        reset = 1'b1;
        cyc();
        chk("mid_reset_out", 32'(dsm_out), 32'd0);
        chk("mid_reset_strobe", 32'(dsm_strobe), 32'd0);
        reset = 1'b0;
        cyc();
        chk("ready_after_reset", 32'(pcm_ready), 32'd1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (dsm_strobe === 1'b1) cnt++;
        end
        chk("idle_strobes", 32'(cnt), 32'd0);
        n_codes = 0;
        pcm_in = 16'h2000; pcm_valid = 1'b1;
        cyc();
        pcm_valid = 1'b0;
        run_strobes(2, 100);
        chk("restart_code0", 32'(codes[0]), 32'd2);
        chk("restart_code1", 32'(codes[1]), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
